// File: rtl/serial_port_scheduler.sv
// Bus-master sequencer for the serial interface processor port: polls status,
// drains received bytes and round-robin shares the transmitter between A and B.
module serial_port_scheduler #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned RX_STATUS_BIT = 0,
  parameter int unsigned TX_STATUS_BIT = 5
) (
  input  logic       clock,
  input  logic       reset_,
  output logic       s_,
  output logic       ior_,
  output logic       iow_,
  output logic       a0,
  inout  wire  [7:0] d7_d0,
  input  logic       tx_req_a,
  input  logic [7:0] tx_byte_a,
  output logic       tx_ack_a,
  input  logic       tx_req_b,
  input  logic [7:0] tx_byte_b,
  output logic       tx_ack_b,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [3:0] {
    DECIDE,
    ST_SETUP, ST_STROBE, ST_RECOVER,
    RX_SETUP, RX_STROBE, RX_RECOVER,
    TX_SETUP, TX_STROBE, TX_RECOVER
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          rx_ready, tx_ready, fresh;
  logic          ptr_b, grant_b, grant_b_next;
  logic [7:0]    tx_data;
  logic          drive, last_strobe;

  assign last_strobe  = (cnt == CW'(1));
  assign grant_b_next = tx_req_b && (!tx_req_a || ptr_b);
  assign d7_d0        = drive ? tx_data : 'z;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= DECIDE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_       = 1'b0;
    ior_     = 1'b1;
    iow_     = 1'b1;
    a0       = 1'b0;
    drive    = 1'b0;
    tx_ack_a = 1'b0;
    tx_ack_b = 1'b0;
    rx_valid = 1'b0;
    case (state)
      DECIDE: begin
        s_ = 1'b1;
        // Data accesses only act on a status sample taken since the last data access
        if (fresh && rx_ready)                               next_state = RX_SETUP;
        else if (fresh && tx_ready && (tx_req_a || tx_req_b)) next_state = TX_SETUP;
        else                                                 next_state = ST_SETUP;
      end
      ST_SETUP:   next_state = ST_STROBE;
      ST_STROBE: begin
        ior_ = 1'b0;
        if (last_strobe) next_state = ST_RECOVER;
      end
      ST_RECOVER: next_state = DECIDE;
      RX_SETUP: begin
        a0 = 1'b1;
        next_state = RX_STROBE;
      end
      RX_STROBE: begin
        a0   = 1'b1;
        ior_ = 1'b0;
        if (last_strobe) next_state = RX_RECOVER;
      end
      RX_RECOVER: begin
        a0       = 1'b1;
        rx_valid = 1'b1;
        next_state = DECIDE;
      end
      TX_SETUP: begin
        a0    = 1'b1;
        drive = 1'b1;
        next_state = TX_STROBE;
      end
      TX_STROBE: begin
        a0    = 1'b1;
        drive = 1'b1;
        iow_  = 1'b0;
        if (last_strobe) next_state = TX_RECOVER;
      end
      TX_RECOVER: begin
        a0       = 1'b1;
        drive    = 1'b1;
        tx_ack_a = !grant_b;
        tx_ack_b = grant_b;
        next_state = DECIDE;
      end
      default: next_state = DECIDE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      cnt      <= '0;
      rx_ready <= 1'b0;
      tx_ready <= 1'b0;
      fresh    <= 1'b0;
      ptr_b    <= 1'b0;
      grant_b  <= 1'b0;
      tx_data  <= '0;
      rx_byte  <= '0;
    end else begin
      case (state)
        DECIDE: begin
          if (next_state != ST_SETUP) fresh <= 1'b0;
          if (next_state == TX_SETUP) begin
            grant_b <= grant_b_next;
            ptr_b   <= !grant_b_next;
            tx_data <= grant_b_next ? tx_byte_b : tx_byte_a;
          end
        end
        ST_SETUP, RX_SETUP, TX_SETUP: cnt <= CW'(ACCESS_CYCLES);
        ST_STROBE: begin
          cnt <= cnt - CW'(1);
          if (last_strobe) begin
            // Written as if/else so an undriven or unknown status bit reads as 0
            if (d7_d0[RX_STATUS_BIT] == 1'b1) rx_ready <= 1'b1;
            else                              rx_ready <= 1'b0;
            if (d7_d0[TX_STATUS_BIT] == 1'b1) tx_ready <= 1'b1;
            else                              tx_ready <= 1'b0;
            fresh <= 1'b1;
          end
        end
        RX_STROBE: begin
          cnt <= cnt - CW'(1);
          if (last_strobe) rx_byte <= d7_d0;
        end
        TX_STROBE: cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule
